// File: rtl/chroma_cfg_ctrl.sv
// Button-driven chroma-key configuration controller; edits are applied on the vsync rising edge.
// Optional CHROMA_CFG_AUTOREPEAT_EN enables press-and-hold auto-repeat (WAIT/RPT states and ms prescaler).
module chroma_cfg_ctrl #(
   parameter int unsigned CLK_HZ    = 100_000_000,
   parameter int unsigned HOLD_MS   = 500,
   parameter int unsigned REPEAT_MS = 100,
   parameter int unsigned STEP      = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       up_rise,
   input  logic       up_fall,
   input  logic       dn_rise,
   input  logic       dn_fall,
   input  logic       sel_rise,
   input  logic       vsync,
   output logic [1:0] sel_field,
   output logic [7:0] cfg_key_r,
   output logic [7:0] cfg_key_g,
   output logic [7:0] cfg_key_b,
   output logic [7:0] cfg_tol,
   output logic       cfg_update,
   output logic       dirty
);

   if (STEP < 1 || STEP > 255 || CLK_HZ < 1000 || HOLD_MS < 1 || REPEAT_MS < 1) begin : g_param_check
      $error("chroma_cfg_ctrl: parameter out of range");
   end

   // Index 0..3 = R, G, B, TOL.
   localparam logic [3:0][7:0] RESET_SET = {8'd32, 8'd0, 8'd255, 8'd0};
   localparam logic [7:0]      STEP8     = 8'(STEP);
   localparam logic [7:0]      UP_LIMIT  = 8'(255 - STEP);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
`ifdef CHROMA_CFG_AUTOREPEAT_EN
      ST_WAIT    = 2'd1,
      ST_RPT     = 2'd2
`else
      ST_PRESSED = 2'd1
`endif
   } state_t;

   state_t          state, state_nxt;
   logic            dir_up, dir_nxt;
   logic [1:0]      sel_nxt;
   logic            step;
   logic            dir_fall;
   logic            vsync_q;
   logic            apply;
   logic [7:0]      cur;
   logic [3:0][7:0] work, work_nxt, cfg;

   assign dir_fall = dir_up ? up_fall : dn_fall;

`ifdef CHROMA_CFG_AUTOREPEAT_EN
   localparam int unsigned MS_DIV = CLK_HZ / 1000;
   localparam int unsigned PW     = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
   localparam int unsigned CMAX   = (HOLD_MS > REPEAT_MS) ? HOLD_MS : REPEAT_MS;
   localparam int unsigned CW     = $clog2(CMAX + 1);

   logic [PW-1:0] presc;
   logic [CW-1:0] ms_cnt;
   logic          tick;
   logic          press;
   logic          cnt_clr;

   assign tick = (presc == PW'(MS_DIV - 1));

   // A press restarts the prescaler so the hold delay is measured from the press itself.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         presc  <= '0;
         ms_cnt <= '0;
      end else begin
         presc <= (press || tick) ? '0 : presc + 1'b1;
         if (cnt_clr)   ms_cnt <= '0;
         else if (tick) ms_cnt <= ms_cnt + 1'b1;
      end
   end
`endif

   always_comb begin
      // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
      state_nxt = state;
      dir_nxt   = dir_up;
      sel_nxt   = sel_field;
      step      = 1'b0;
`ifdef CHROMA_CFG_AUTOREPEAT_EN
      press     = 1'b0;
      cnt_clr   = 1'b0;
`endif
      case (state)
         ST_IDLE: begin
            if (up_rise ^ dn_rise) begin
               step    = 1'b1;
               dir_nxt = up_rise;
`ifdef CHROMA_CFG_AUTOREPEAT_EN
               press     = 1'b1;
               cnt_clr   = 1'b1;
               state_nxt = ST_WAIT;
`else
               state_nxt = ST_PRESSED;
`endif
            end else if (sel_rise && !up_rise && !dn_rise) begin
               sel_nxt = sel_field + 2'd1;
            end
         end
`ifdef CHROMA_CFG_AUTOREPEAT_EN
         ST_WAIT: begin
            if (dir_fall) begin
               state_nxt = ST_IDLE;
            end else if (tick && ms_cnt == CW'(HOLD_MS - 1)) begin
               step      = 1'b1;
               cnt_clr   = 1'b1;
               state_nxt = ST_RPT;
            end
         end
         ST_RPT: begin
            if (dir_fall) begin
               state_nxt = ST_IDLE;
            end else if (tick && ms_cnt == CW'(REPEAT_MS - 1)) begin
               step    = 1'b1;
               cnt_clr = 1'b1;
            end
         end
`else
         ST_PRESSED: begin
            if (dir_fall) state_nxt = ST_IDLE;
         end
`endif
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Saturating step on the selected field; direction is the one being latched this cycle.
   always_comb begin
      work_nxt = work;
      cur      = work[sel_field];
      if (step) begin
         if (dir_nxt) work_nxt[sel_field] = (cur > UP_LIMIT) ? 8'd255 : cur + STEP8;
         else         work_nxt[sel_field] = (cur < STEP8)    ? 8'd0   : cur - STEP8;
      end
   end

   // A step coinciding with the vsync edge counts as pending, so it is applied in the same copy.
   assign apply = vsync && !vsync_q && (dirty || step);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= ST_IDLE;
         dir_up     <= 1'b0;
         sel_field  <= 2'd0;
         work       <= RESET_SET;
         cfg        <= RESET_SET;
         dirty      <= 1'b0;
         cfg_update <= 1'b0;
         vsync_q    <= 1'b0;
      end else begin
         state      <= state_nxt;
         dir_up     <= dir_nxt;
         sel_field  <= sel_nxt;
         work       <= work_nxt;
         vsync_q    <= vsync;
         cfg_update <= apply;
         dirty      <= apply ? 1'b0 : (dirty || step);
         if (apply) cfg <= work_nxt;
      end
   end

   assign cfg_key_r = cfg[0];
   assign cfg_key_g = cfg[1];
   assign cfg_key_b = cfg[2];
   assign cfg_tol   = cfg[3];

endmodule
